// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the two-port byte-write-enable BRAM arbiter.
package bram_arb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 9;
  localparam int unsigned DEF_DI_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_e;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

endpackage

// File: rtl/bram_byte_we_arbiter_rr_arb2.sv
// Two-input grant logic with eligibility masks; round-robin on conflict,
// or A-wins fixed priority when ARB_FIXED_PRIO_EN is defined.
module rr_arb2
  import bram_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic elig_a_i,
  input  logic elig_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic ra;
  logic rb;

  assign ra = req_a_i & elig_a_i & ~rst_i;
  assign rb = req_b_i & elig_b_i & ~rst_i;

`ifdef ARB_FIXED_PRIO_EN
  logic unused_clk;
  assign unused_clk = clk_i;

  always_comb begin
    gnt_a_o = ra;
    gnt_b_o = rb & ~ra;
  end
`else
  sel_e last_q;
  sel_e last_d;

  always_comb begin
    gnt_a_o = ra & (~rb | (last_q == SEL_B));
    gnt_b_o = rb & ~gnt_a_o;
    last_d  = last_q;
    if (gnt_a_o)      last_d = SEL_A;
    else if (gnt_b_o) last_d = SEL_B;
  end

  // B recorded as last so A wins the first conflict after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= SEL_B;
    else       last_q <= last_d;
  end
`endif

endmodule

// File: rtl/bram_byte_we_arbiter.sv
// Arbiter sharing one read-first byte-WE BRAM port between requesters A and B.
// Optional build macro: ARB_FIXED_PRIO_EN (A always wins conflicts in IDLE).
module bram_byte_we_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DI_WIDTH   = DEF_DI_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    a_req,
  input  logic                    a_lock,
  input  logic [1:0]              a_we,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [2*DI_WIDTH-1:0]   a_di,
  output logic                    a_gnt,
  output logic                    a_rvalid,
  output logic [2*DI_WIDTH-1:0]   a_do,
  input  logic                    b_req,
  input  logic                    b_lock,
  input  logic [1:0]              b_we,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [2*DI_WIDTH-1:0]   b_di,
  output logic                    b_gnt,
  output logic                    b_rvalid,
  output logic [2*DI_WIDTH-1:0]   b_do,
  output logic [1:0]              ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [2*DI_WIDTH-1:0]   ram_di,
  input  logic [2*DI_WIDTH-1:0]   ram_do
);

  state_e state_q;
  state_e state_d;
  logic   a_rvalid_q;
  logic   b_rvalid_q;

  rr_arb2 u_arb (
    .clk_i    (CLK),
    .rst_i    (RST),
    .req_a_i  (a_req),
    .req_b_i  (b_req),
    .elig_a_i (state_q != LOCK_B),
    .elig_b_i (state_q != LOCK_A),
    .gnt_a_o  (a_gnt),
    .gnt_b_o  (b_gnt)
  );

  // Lock persists across cycles where the owner is not requesting.
  always_comb begin
    state_d = state_q;
    if (a_gnt)      state_d = a_lock ? LOCK_A : IDLE;
    else if (b_gnt) state_d = b_lock ? LOCK_B : IDLE;
  end

  always_comb begin
    ram_we   = '0;
    ram_addr = '0;
    ram_di   = '0;
    if (a_gnt) begin
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_di   = a_di;
    end else if (b_gnt) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_di   = b_di;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_rvalid_q <= a_gnt;
      b_rvalid_q <= b_gnt;
    end
  end

  assign a_rvalid = a_rvalid_q & ~RST;
  assign b_rvalid = b_rvalid_q & ~RST;
  assign a_do     = a_rvalid ? ram_do : '0;
  assign b_do     = b_rvalid ? ram_do : '0;

endmodule

// File: tb/tb_bram_byte_we_arbiter.sv
// Directed bench for bram_byte_we_arbiter with a behavioural read-first byte-WE RAM.
module tb_bram_byte_we_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 16;

  logic          CLK;
  logic          RST;
  logic          a_req, a_lock, b_req, b_lock;
  logic [1:0]    a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_di, b_di;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_do, b_do;
  logic [1:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp;
  int n_fail;

  bram_byte_we_arbiter #(.ADDR_WIDTH(AW), .DI_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_di(a_di),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_do(a_do),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_di(b_di),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_do(b_do),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    ram_do <= mem[ram_addr];
    if (ram_we[0]) mem[ram_addr][7:0]  <= ram_di[7:0];
    if (ram_we[1]) mem[ram_addr][15:8] <= ram_di[15:8];
  end

  task automatic set_a(input logic req, input logic lock, input logic [1:0] we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] di);
    a_req = req; a_lock = lock; a_we = we; a_addr = addr; a_di = di;
  endtask

  task automatic set_b(input logic req, input logic lock, input logic [1:0] we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] di);
    b_req = req; b_lock = lock; b_we = we; b_addr = addr; b_di = di;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    set_a(1'b1, 1'b1, 2'b11, 9'h010, 16'hFFFF);
    set_b(1'b1, 1'b0, 2'b11, 9'h011, 16'hFFFF);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); #1;
      n_cmp++;
      if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we} !== 6'b0) begin
        n_fail++;
        $display("FAIL rst_forced: got gnt=%b%b rv=%b%b we=%b want all 0",
                 a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we);
      end
    end
    @(negedge CLK);
    RST = 1'b0;
    set_a(1'b0, 1'b0, 2'b00, '0, '0);
    set_b(1'b0, 1'b0, 2'b00, '0, '0);
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, ram_addr, ram_di, a_do, b_do} !== '0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got gnt=%b%b rv=%b%b we=%b addr=%h di=%h ado=%h bdo=%h want all 0",
                 i, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, ram_addr, ram_di, a_do, b_do);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_alternation;
    logic exp_a, exp_b, prev_a, prev_b;
    prev_a = 1'b0; prev_b = 1'b0;
    set_a(1'b1, 1'b0, 2'b00, 9'h100, '0);
    set_b(1'b1, 1'b0, 2'b00, 9'h101, '0);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin
        set_a(1'b0, 1'b0, 2'b00, '0, '0);
        set_b(1'b0, 1'b0, 2'b00, '0, '0);
      end
`ifdef ARB_FIXED_PRIO_EN
      exp_a = (i < 6);
      exp_b = 1'b0;
`else
      exp_a = (i < 6) && (i % 2 == 0);
      exp_b = (i < 6) && (i % 2 == 1);
`endif
      #1;
      n_cmp++;
      if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== {exp_a, exp_b, prev_a, prev_b}) begin
        n_fail++;
        $display("FAIL alt_cycle%0d: got gnt=%b%b rv=%b%b want gnt=%b%b rv=%b%b",
                 i, a_gnt, b_gnt, a_rvalid, b_rvalid, exp_a, exp_b, prev_a, prev_b);
      end
      if (exp_a || exp_b) begin
        n_cmp++;
        if (ram_addr !== (exp_a ? 9'h100 : 9'h101)) begin
          n_fail++;
          $display("FAIL alt_addr%0d: got %h want %h", i, ram_addr, exp_a ? 9'h100 : 9'h101);
        end
      end
      prev_a = exp_a; prev_b = exp_b;
      @(negedge CLK);
    end
  endtask

  task automatic test_write_read;
    set_a(1'b1, 1'b0, 2'b11, 9'h010, 16'hBEEF);
    #1;
    n_cmp++;
    if ({a_gnt, b_gnt, ram_we, ram_addr, ram_di} !== {1'b1, 1'b0, 2'b11, 9'h010, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL wr_issue: got gnt=%b%b we=%b addr=%h di=%h want gnt=10 we=11 addr=010 di=beef",
               a_gnt, b_gnt, ram_we, ram_addr, ram_di);
    end
    @(negedge CLK);
    set_a(1'b1, 1'b0, 2'b00, 9'h010, 16'h0000);
    #1;
    n_cmp++;
    if ({a_rvalid, b_rvalid, a_do, a_gnt, ram_we} !== {1'b1, 1'b0, 16'h0000, 1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL wr_resp: got rv=%b%b ado=%h gnt=%b we=%b want rv=10 ado=0000 gnt=1 we=00",
               a_rvalid, b_rvalid, a_do, a_gnt, ram_we);
    end
    @(negedge CLK);
    set_a(1'b0, 1'b0, 2'b00, '0, '0);
    #1;
    n_cmp++;
    if ({a_rvalid, a_do, a_gnt} !== {1'b1, 16'hBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL rd_resp: got rv=%b ado=%h gnt=%b want rv=1 ado=beef gnt=0", a_rvalid, a_do, a_gnt);
    end
    @(negedge CLK); #1;
    n_cmp++;
    if ({a_rvalid, a_do} !== {1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL rd_once: got rv=%b ado=%h want rv=0 ado=0000", a_rvalid, a_do);
    end
    @(negedge CLK);
  endtask

  task automatic test_byte_lanes;
    set_a(1'b1, 1'b0, 2'b11, 9'h020, 16'h1234);
    @(negedge CLK);
    set_a(1'b0, 1'b0, 2'b00, '0, '0);
    set_b(1'b1, 1'b0, 2'b01, 9'h020, 16'hAAFF);
    #1;
    n_cmp++;
    if ({b_gnt, ram_we, ram_di, a_rvalid, a_do} !== {1'b1, 2'b01, 16'hAAFF, 1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL bl_issue: got bgnt=%b we=%b di=%h arv=%b ado=%h want 1 01 aaff 1 0000",
               b_gnt, ram_we, ram_di, a_rvalid, a_do);
    end
    @(negedge CLK);
    set_b(1'b1, 1'b0, 2'b00, 9'h020, '0);
    #1;
    n_cmp++;
    if ({b_rvalid, b_do, a_rvalid, a_do} !== {1'b1, 16'h1234, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL bl_old: got brv=%b bdo=%h arv=%b ado=%h want 1 1234 0 0000",
               b_rvalid, b_do, a_rvalid, a_do);
    end
    @(negedge CLK);
    set_b(1'b0, 1'b0, 2'b00, '0, '0);
    #1;
    n_cmp++;
    if ({b_rvalid, b_do} !== {1'b1, 16'h12FF}) begin
      n_fail++;
      $display("FAIL bl_merge: got brv=%b bdo=%h want 1 12ff", b_rvalid, b_do);
    end
    @(negedge CLK);
  endtask

  task automatic test_lock;
    set_a(1'b1, 1'b1, 2'b00, 9'h030, '0);
    set_b(1'b1, 1'b0, 2'b00, 9'h031, '0);
    #1;
    n_cmp++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL lk_take: got gnt=%b%b want 10", a_gnt, b_gnt);
    end
    @(negedge CLK);
    set_a(1'b0, 1'b0, 2'b00, '0, '0);
    #1;
    n_cmp++;
    if ({a_gnt, b_gnt, a_rvalid, a_do, ram_we} !== {2'b00, 1'b1, 16'h0000, 2'b00}) begin
      n_fail++;
      $display("FAIL lk_hold: got gnt=%b%b arv=%b ado=%h we=%b want 00 1 0000 00",
               a_gnt, b_gnt, a_rvalid, a_do, ram_we);
    end
    @(negedge CLK);
    set_a(1'b1, 1'b0, 2'b11, 9'h030, 16'h5555);
    #1;
    n_cmp++;
    if ({a_gnt, b_gnt, a_rvalid, ram_we} !== {2'b10, 1'b0, 2'b11}) begin
      n_fail++;
      $display("FAIL lk_write: got gnt=%b%b arv=%b we=%b want 10 0 11", a_gnt, b_gnt, a_rvalid, ram_we);
    end
    @(negedge CLK);
    set_a(1'b0, 1'b0, 2'b00, '0, '0);
    #1;
    n_cmp++;
    if ({a_gnt, b_gnt, a_rvalid, a_do, ram_addr} !== {2'b01, 1'b1, 16'h0000, 9'h031}) begin
      n_fail++;
      $display("FAIL lk_release: got gnt=%b%b arv=%b ado=%h addr=%h want 01 1 0000 031",
               a_gnt, b_gnt, a_rvalid, a_do, ram_addr);
    end
    @(negedge CLK);
    set_b(1'b0, 1'b0, 2'b00, '0, '0);
    #1;
    n_cmp++;
    if ({b_rvalid, b_do, a_rvalid} !== {1'b1, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL lk_bresp: got brv=%b bdo=%h arv=%b want 1 0000 0", b_rvalid, b_do, a_rvalid);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_in_lock;
    set_a(1'b1, 1'b1, 2'b00, 9'h030, '0);
    set_b(1'b1, 1'b0, 2'b00, 9'h030, '0);
    #1;
    n_cmp++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL rl_take: got gnt=%b%b want 10", a_gnt, b_gnt);
    end
    @(negedge CLK);
    set_a(1'b0, 1'b0, 2'b00, '0, '0);
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_do, ram_we} !== '0) begin
      n_fail++;
      $display("FAIL rl_discard: got gnt=%b%b rv=%b%b ado=%h we=%b want all 0",
               a_gnt, b_gnt, a_rvalid, b_rvalid, a_do, ram_we);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({a_gnt, b_gnt, a_rvalid} !== 3'b010) begin
      n_fail++;
      $display("FAIL rl_bgrant: got gnt=%b%b arv=%b want 01 0", a_gnt, b_gnt, a_rvalid);
    end
    @(negedge CLK);
    set_b(1'b0, 1'b0, 2'b00, '0, '0);
    #1;
    n_cmp++;
    if ({b_rvalid, b_do, a_rvalid} !== {1'b1, 16'h5555, 1'b0}) begin
      n_fail++;
      $display("FAIL rl_bresp: got brv=%b bdo=%h arv=%b want 1 5555 0", b_rvalid, b_do, a_rvalid);
    end
    @(negedge CLK);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    RST = 1'b1;
    set_a(1'b0, 1'b0, 2'b00, '0, '0);
    set_b(1'b0, 1'b0, 2'b00, '0, '0);
    test_reset();
    test_alternation();
    test_write_read();
    test_byte_lanes();
    test_lock();
    test_reset_in_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
